// File: rtl/tc_pkg.sv
// Shared types and constants for the test-case stream reader.
package tc_pkg;

  localparam int NUM_CLASSES     = 10;
  localparam int VEC_LEN_DEFAULT = 401;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    FETCH,
    STREAM,
    WAIT_RES,
    CHECK,
    DONE
  } tc_state_t;

endpackage

// File: rtl/tc_stream_reader_if.sv
// Element stream to the inference engine plus its classification return path.
interface tc_stream_reader_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLASS_WIDTH = 4
);

  logic                         px_valid;
  logic signed [DATA_WIDTH-1:0] px_data;
  logic                         px_last;
  logic                         px_ready;
  logic                         res_valid;
  logic [CLASS_WIDTH-1:0]       res_class;

  modport master (
    output px_valid, px_data, px_last,
    input  px_ready, res_valid, res_class
  );

  modport slave (
    input  px_valid, px_data, px_last,
    output px_ready, res_valid, res_class
  );

endinterface

// File: rtl/tc_scoreboard.sv
// Label compare, saturating pass/fail/total counters and the sticky protocol-error flag.
module tc_scoreboard
  import tc_pkg::*;
#(
  parameter int CLASS_WIDTH = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   check,
  input  logic                   stray,
  input  logic [31:0]            exp_y,
  input  logic [CLASS_WIDTH-1:0] res_class,
  output logic [CNT_WIDTH-1:0]   tc_count,
  output logic [CNT_WIDTH-1:0]   pass_count,
  output logic [CNT_WIDTH-1:0]   fail_count,
  output logic                   proto_err
);

  logic match;

  // Labels outside the class range can never match, whatever the low bits say.
  assign match = (exp_y < 32'(NUM_CLASSES)) && (res_class == exp_y[CLASS_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tc_count   <= '0;
      pass_count <= '0;
      fail_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (check) begin
        if (match) begin
          if (~&pass_count) pass_count <= pass_count + CNT_WIDTH'(1);
        end else begin
          if (~&fail_count) fail_count <= fail_count + CNT_WIDTH'(1);
        end
        if (~&tc_count) tc_count <= tc_count + CNT_WIDTH'(1);
      end
      if (stray) proto_err <= 1'b1;
    end
  end

endmodule

// File: rtl/tc_stream_reader.sv
// Initiator-side reader: loads each test case, streams its elements to the engine
// and scores the returned classification.
module tc_stream_reader
  import tc_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int VEC_LEN        = VEC_LEN_DEFAULT,
  parameter int TEST_CASES_NUM = 5000,
  parameter int CLASS_WIDTH    = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         next_tc,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_data,
  input  logic [31:0]                  exp_y,
  tc_stream_reader_if.master           eng,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_WIDTH-1:0]         tc_count,
  output logic [CNT_WIDTH-1:0]         pass_count,
  output logic [CNT_WIDTH-1:0]         fail_count,
  output logic                         proto_err
);

  if ((VEC_LEN < 1) || (VEC_LEN > (1 << ADDR_WIDTH))) begin : g_bad_vec_len
    $error("VEC_LEN does not fit in the ADDR_WIDTH address space");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VEC_LEN - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_TC  = CNT_WIDTH'(TEST_CASES_NUM - 1);

  tc_state_t              state;
  tc_state_t              state_nx;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [CLASS_WIDTH-1:0] res_q;
  logic                   handshake;
  logic                   run_start;
  logic                   check_stb;
  logic                   stray;

  assign handshake = eng.px_valid && eng.px_ready;
  assign run_start = start && ((state == IDLE) || (state == DONE));
  assign stray     = eng.res_valid && (state != WAIT_RES);

  // NOTE: state flops use non-blocking assignment so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = LOAD;
      LOAD:       state_nx = SETTLE;
      SETTLE:     state_nx = FETCH;
      FETCH:      state_nx = STREAM;
      STREAM:     if (handshake) state_nx = eng.px_last ? WAIT_RES : FETCH;
      WAIT_RES:   if (eng.res_valid) state_nx = CHECK;
      CHECK:      state_nx = (tc_count == LAST_TC) ? DONE : LOAD;
      default:    state_nx = IDLE;
    endcase
  end

  // Moore outputs decoded straight from the state flops, so they change only at clock edges.
  always_comb begin
    next_tc   = (state == LOAD);
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    check_stb = (state == CHECK);
    mem_addr  = idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      eng.px_valid <= 1'b0;
      eng.px_data  <= '0;
      eng.px_last  <= 1'b0;
      res_q        <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) idx <= '0;
        FETCH: begin
          eng.px_data  <= mem_data;
          eng.px_valid <= 1'b1;
          eng.px_last  <= (idx == LAST_IDX);
        end
        STREAM: if (handshake) begin
          eng.px_valid <= 1'b0;
          if (!eng.px_last) idx <= idx + ADDR_WIDTH'(1);
        end
        WAIT_RES: if (eng.res_valid) res_q <= eng.res_class;
        CHECK:    idx <= '0;
        default: ;
      endcase
    end
  end

  tc_scoreboard #(
    .CLASS_WIDTH (CLASS_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .clear      (run_start),
    .check      (check_stb),
    .stray      (stray),
    .exp_y      (exp_y),
    .res_class  (res_q),
    .tc_count   (tc_count),
    .pass_count (pass_count),
    .fail_count (fail_count),
    .proto_err  (proto_err)
  );

endmodule

// File: tb/tb_tc_stream_reader.sv
// Randomised bench for tc_stream_reader with a memory model, an engine responder and a stream monitor.
module tb_tc_stream_reader;
  import tc_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int VL = 401;
  localparam int TCN = 2;
  localparam int CW = 4;
  localparam int NW = 32;
  localparam int CYC_LIMIT = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic next_tc;
  logic [AW-1:0] mem_addr;
  logic signed [DW-1:0] mem_data;
  logic [31:0] exp_y;
  logic busy, done, proto_err;
  logic [NW-1:0] tc_count, pass_count, fail_count;

  tc_stream_reader_if #(.DATA_WIDTH(DW), .CLASS_WIDTH(CW)) eng ();

  tc_stream_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VEC_LEN(VL), .TEST_CASES_NUM(TCN),
    .CLASS_WIDTH(CW), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .next_tc(next_tc), .mem_addr(mem_addr),
    .mem_data(mem_data), .exp_y(exp_y), .eng(eng), .busy(busy), .done(done),
    .tc_count(tc_count), .pass_count(pass_count), .fail_count(fail_count),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model: each next_tc strobe exposes the next stored test case.
  logic [DW-1:0] vecs [TCN][VL];
  int exps [TCN];
  int resp [TCN];
  int tc_ptr = 0;
  int cur_tc = 0;

  always @(posedge clk) begin
    if (rst) begin
      tc_ptr <= 0;
      cur_tc <= 0;
      exp_y  <= '0;
    end else begin
      if (start && !busy) tc_ptr <= 0;
      if (next_tc && tc_ptr < TCN) begin
        cur_tc <= tc_ptr;
        exp_y  <= 32'(exps[tc_ptr]);
        tc_ptr <= tc_ptr + 1;
      end
    end
  end

  assign mem_data = (int'(mem_addr) < VL) ? vecs[cur_tc][mem_addr] : '0;

  // Monitor: accepted beats, next_tc pulse shape and hold stability under back-pressure.
  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  beat_t got [$];
  int ntc_pulses = 0;
  int ntc_double = 0;
  int unstable = 0;
  logic prev_ntc = 1'b0, prev_hold = 1'b0, prev_rst = 1'b0, prev_l = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge clk) begin
    if (eng.px_valid && eng.px_ready) got.push_back({eng.px_data, eng.px_last});
    if (next_tc) ntc_pulses++;
    if (next_tc && prev_ntc) ntc_double++;
    if (prev_hold && !prev_rst &&
        !(eng.px_valid && eng.px_data == prev_d && eng.px_last == prev_l)) unstable++;
    prev_ntc  = next_tc;
    prev_hold = eng.px_valid && !eng.px_ready;
    prev_d    = eng.px_data;
    prev_l    = eng.px_last;
    prev_rst  = rst;
  end

  // Reference: a run streams test case 0 then 1, each element in address order, last flag on the final word.
  function automatic int stream_bad(int base, int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      int t;
      int e;
      t = k / VL;
      e = k % VL;
      if (base + k >= got.size()) bad++;
      else if (got[base+k].d !== vecs[t][e] || got[base+k].l !== (e == VL - 1)) bad++;
    end
    return bad;
  endfunction

  function automatic int model_pass();
    int p = 0;
    for (int i = 0; i < TCN; i++)
      if (exps[i] >= 0 && exps[i] < NUM_CLASSES && resp[i] == exps[i]) p++;
    return p;
  endfunction

  task automatic randomize_vecs();
    for (int t = 0; t < TCN; t++)
      for (int e = 0; e < VL; e++) vecs[t][e] = DW'($urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Drives px_ready/res_valid/start each cycle until done (or abort_at beats); returns ok=0 on timeout.
  task automatic run_loop(input int ready_pct, input int stray_at, input int start_at,
                          input int abort_at, output bit ok);
    int base;
    int n_res = 0;
    bit pend = 0, stray_pend = 0, start_pend = 0, stray_done = 0, start_done = 0;
    base = got.size();
    ok = 0;
    for (int cyc = 0; cyc < CYC_LIMIT; cyc++) begin
      eng.px_ready  = ($urandom_range(99) < ready_pct);
      eng.res_valid = pend | stray_pend;
      eng.res_class = pend ? CW'(resp[n_res-1]) : CW'($urandom_range(15));
      start = start_pend;
      pend = 0; stray_pend = 0; start_pend = 0;
      @(negedge clk); #1;
      if (eng.px_valid && eng.px_ready && eng.px_last) begin pend = 1; n_res++; end
      if (stray_at >= 0 && !stray_done && got.size() - base >= stray_at) begin
        stray_pend = 1; stray_done = 1;
      end
      if (start_at >= 0 && !start_done && got.size() - base >= start_at) begin
        start_pend = 1; start_done = 1;
      end
      if (abort_at >= 0 && got.size() - base >= abort_at) begin ok = 1; break; end
      if (done) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    eng.res_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({next_tc, busy, done, eng.px_valid, eng.px_last, proto_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000",
                         {next_tc, busy, done, eng.px_valid, eng.px_last, proto_err});
    end
    checks++;
    if (eng.px_data !== '0 || mem_addr !== '0) begin
      errors++; $display("FAIL reset_data px_data=%0d mem_addr=%0d want 0/0", eng.px_data, mem_addr);
    end
    checks++;
    if (tc_count !== '0 || pass_count !== '0 || fail_count !== '0) begin
      errors++; $display("FAIL reset_counts tc=%0d pass=%0d fail=%0d want 0", tc_count, pass_count, fail_count);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic_run();
    int base, p0, d0;
    bit ok;
    randomize_vecs();
    exps[0] = 7; resp[0] = 7;
    exps[1] = 5; resp[1] = 3;
    base = got.size(); p0 = ntc_pulses; d0 = ntc_double;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_busy_after_start busy=%b done=%b want 1/0", busy, done);
    end
    run_loop(100, -1, -1, -1, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++;
    if (ntc_pulses - p0 !== 2 || ntc_double - d0 !== 0) begin
      errors++; $display("FAIL basic_next_tc pulses=%0d doubles=%0d want 2/0", ntc_pulses - p0, ntc_double - d0);
    end
    checks++;
    if (got.size() - base !== 2 * VL) begin
      errors++; $display("FAIL basic_handshakes got %0d want %0d", got.size() - base, 2 * VL);
    end
    checks++;
    if (stream_bad(base, 2 * VL) !== 0) begin
      errors++; $display("FAIL basic_stream bad_beats=%0d want 0", stream_bad(base, 2 * VL));
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done done=%b busy=%b want 1/0", done, busy);
    end
    checks++;
    if (pass_count !== 1 || fail_count !== 1 || tc_count !== 2 || proto_err !== 1'b0) begin
      errors++; $display("FAIL basic_counts pass=%0d fail=%0d tc=%0d perr=%b want 1/1/2/0",
                         pass_count, fail_count, tc_count, proto_err);
    end
  endtask

  task automatic test_stall();
    int base, u0, p;
    bit ok;
    randomize_vecs();
    for (int i = 0; i < TCN; i++) begin
      exps[i] = $urandom_range(9);
      resp[i] = ($urandom_range(1) == 1) ? exps[i] : $urandom_range(9);
    end
    p = model_pass();
    base = got.size(); u0 = unstable;
    pulse_start();
    run_loop(30, -1, -1, -1, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout got no done want done"); end
    checks++;
    if (unstable - u0 !== 0) begin
      errors++; $display("FAIL stall_hold changes=%0d want 0", unstable - u0);
    end
    checks++;
    if (got.size() - base !== 2 * VL || stream_bad(base, 2 * VL) !== 0) begin
      errors++; $display("FAIL stall_stream beats=%0d bad=%0d want %0d/0",
                         got.size() - base, stream_bad(base, 2 * VL), 2 * VL);
    end
    checks++;
    if (pass_count !== NW'(p) || fail_count !== NW'(TCN - p) || tc_count !== NW'(TCN)) begin
      errors++; $display("FAIL stall_counts pass=%0d fail=%0d tc=%0d want %0d/%0d/%0d",
                         pass_count, fail_count, tc_count, p, TCN - p, TCN);
    end
  endtask

  task automatic test_proto_err();
    bit ok;
    int base;
    randomize_vecs();
    exps[0] = 3; resp[0] = 3;
    exps[1] = 3; resp[1] = 1;
    pulse_start();
    run_loop(100, 50, -1, -1, ok);
    checks++;
    if (ok !== 1'b1 || proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_sticky ok=%b proto_err=%b want 1/1", ok, proto_err);
    end
    checks++;
    if (pass_count !== 1 || fail_count !== 1 || tc_count !== 2) begin
      errors++; $display("FAIL proto_counts pass=%0d fail=%0d tc=%0d want 1/1/2", pass_count, fail_count, tc_count);
    end
    randomize_vecs();
    resp[1] = 3;
    base = got.size();
    pulse_start();
    checks++;
    if (proto_err !== 1'b0 || tc_count !== '0 || pass_count !== '0 || fail_count !== '0) begin
      errors++; $display("FAIL proto_clear perr=%b tc=%0d pass=%0d fail=%0d want 0",
                         proto_err, tc_count, pass_count, fail_count);
    end
    run_loop(100, -1, -1, -1, ok);
    checks++;
    if (ok !== 1'b1 || proto_err !== 1'b0 || pass_count !== 2 || stream_bad(base, 2 * VL) !== 0) begin
      errors++; $display("FAIL proto_rerun ok=%b perr=%b pass=%0d want 1/0/2", ok, proto_err, pass_count);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int base, p;
    randomize_vecs();
    exps[0] = 1; resp[0] = 1;
    exps[1] = 2; resp[1] = 2;
    base = got.size();
    pulse_start();
    run_loop(100, -1, -1, 123, ok);
    @(posedge clk); #1 eng.px_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (eng.px_valid !== 1'b1 || mem_addr !== AW'(123)) begin
      errors++; $display("FAIL midrst_pre valid=%b addr=%0d want 1/123", eng.px_valid, mem_addr);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({next_tc, busy, done, eng.px_valid, eng.px_last, proto_err} !== 6'b0 ||
        eng.px_data !== '0 || mem_addr !== '0 || tc_count !== '0 || pass_count !== '0 || fail_count !== '0) begin
      errors++; $display("FAIL midrst_outputs flags=%b data=%0d addr=%0d tc=%0d want all 0",
                         {next_tc, busy, done, eng.px_valid, eng.px_last, proto_err},
                         eng.px_data, mem_addr, tc_count);
    end
    checks++;
    if (got.size() - base !== 123 || stream_bad(base, 123) !== 0) begin
      errors++; $display("FAIL midrst_partial beats=%0d want 123", got.size() - base);
    end
    randomize_vecs();
    exps[0] = $urandom_range(9); resp[0] = exps[0];
    exps[1] = $urandom_range(9); resp[1] = (exps[1] + 1) % NUM_CLASSES;
    p = model_pass();
    base = got.size();
    pulse_start();
    checks++;
    if (tc_count !== '0 || mem_addr !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_restart tc=%0d addr=%0d busy=%b want 0/0/1", tc_count, mem_addr, busy);
    end
    run_loop(100, -1, -1, -1, ok);
    checks++;
    if (ok !== 1'b1 || stream_bad(base, 2 * VL) !== 0 || pass_count !== NW'(p) || tc_count !== 2) begin
      errors++; $display("FAIL midrst_rerun ok=%b bad=%0d pass=%0d tc=%0d want 1/0/%0d/2",
                         ok, stream_bad(base, 2 * VL), pass_count, tc_count, p);
    end
  endtask

  task automatic test_out_of_range();
    bit ok;
    int base, p0;
    randomize_vecs();
    exps[0] = 12; resp[0] = 12;
    exps[1] = 3;  resp[1] = 3;
    base = got.size(); p0 = ntc_pulses;
    pulse_start();
    run_loop(100, -1, 200, -1, ok);
    checks++;
    if (ok !== 1'b1 || got.size() - base !== 2 * VL || stream_bad(base, 2 * VL) !== 0 ||
        ntc_pulses - p0 !== 2) begin
      errors++; $display("FAIL oor_stream ok=%b beats=%0d pulses=%0d want 1/%0d/2",
                         ok, got.size() - base, ntc_pulses - p0, 2 * VL);
    end
    checks++;
    if (pass_count !== 1 || fail_count !== 1 || tc_count !== 2) begin
      errors++; $display("FAIL oor_counts pass=%0d fail=%0d tc=%0d want 1/1/2", pass_count, fail_count, tc_count);
    end
  endtask

  initial begin
    eng.px_ready  = 1'b0;
    eng.res_valid = 1'b0;
    eng.res_class = '0;
    for (int i = 0; i < TCN; i++) begin exps[i] = 0; resp[i] = 0; end
    randomize_vecs();
    test_reset();
    test_basic_run();
    test_stall();
    test_proto_err();
    test_mid_reset();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
